// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//   Instruction queue between the fetch (IF) and decode (ID) stages. Fetched
//   {pc, instr} pairs are buffered in a small circular FIFO so the two stages
//   can stall independently. A flush (taken branch / jump) drops every queued
//   instruction in one cycle.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both 1 and flush is 0. ready never depends combinationally on valid
//   (if_ready only on occupancy), and the producer holds its payload stable
//   until the transfer happens.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   if_valid   in   fetch presents an instruction
//   if_pc      in   [31:0] PC of the presented instruction
//   if_instr   in   [31:0] presented instruction word
//   if_ready   out  queue has room (count < DEPTH)
//   flush      in   discard all queued instructions
//   id_ready   in   decode accepts the head entry
//   id_valid   out  head entry is valid (count > 0)
//   id_pc      out  [31:0] PC of head entry, 0 when empty
//   id_instr   out  [31:0] instruction of head entry, NOP (0) when empty
//   count      out  [4:0] occupied entries, 0..DEPTH
//   stall_cnt  out  [15:0] saturating count of cycles with id_valid & !id_ready
// ----------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  count,
  output logic [15:0] stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [4:0]    r_count;
  logic [15:0]   r_stall_cnt;

  logic          w_push;
  logic          w_pop;

  // Full/empty come from the occupancy counter, so the pointers can simply
  // wrap at DEPTH (a power of two) without an extra wrap bit.
  assign if_ready = (r_count < 5'(DEPTH));
  assign id_valid = (r_count != 5'd0);

  // Refusal of a push into a full queue holds even if a pop happens in the
  // same cycle: if_ready looks only at the current count.
  assign w_push = if_valid & if_ready & ~flush;
  assign w_pop  = id_valid & id_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= 5'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (flush) begin
        // Collapse the queue onto the tail; any push or pop this cycle is void.
        r_head  <= r_tail;
        r_count <= 5'd0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 5'd1;
          2'b01:   r_count <= r_count - 5'd1;
          default: r_count <= r_count;
        endcase
      end

      // Flush does not clear the stall counter; it only suppresses counting.
      if (id_valid && !id_ready && !flush && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Entry storage carries no reset: it is only ever observed through the head
  // entry while count > 0, and every such entry was written by a push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]    <= if_pc;
      r_mem_instr[r_tail] <= if_instr;
    end
  end

  // Empty queue presents PC 0 and a NOP rather than stale storage.
  assign id_pc     = id_valid ? r_mem_pc[r_head]    : 32'h0000_0000;
  assign id_instr  = id_valid ? r_mem_instr[r_head] : 32'h0000_0000;
  assign count     = r_count;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
//   Directed + random stimulus for if_id_queue (DEPTH=4). The reference model
//   is a queue of expected {pc, instr} entries plus an expected stall count;
//   accepted pushes are appended, pops remove the front, and the DUT head,
//   occupancy and handshake outputs are compared against it every cycle.
// ----------------------------------------------------------------------------
module tb_if_id_queue;

  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  count;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_ready  (if_ready),
    .flush     (flush),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [15:0] m_stall;
  bit          last_acc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz = exp_q.size();
    check("count",     32'(count),         32'(sz));
    check("if_ready",  32'(if_ready),      32'(sz < DEPTH));
    check("id_valid",  32'(id_valid),      32'(sz > 0));
    check("stall_cnt", 32'(stall_cnt),     32'(m_stall));
    if (sz > 0) begin
      check("id_pc",    id_pc,    exp_q[0][63:32]);
      check("id_instr", id_instr, exp_q[0][31:0]);
    end else begin
      check("id_pc_empty",    id_pc,    32'h0000_0000);
      check("id_instr_empty", id_instr, 32'h0000_0000);
    end
  endtask

  // One clock cycle: optionally compare outputs, predict the edge from the
  // current inputs, advance the model at the edge, return 1 time unit later.
  task automatic step(input bit chk);
    bit push;
    bit pop;
    bit stall;
    int sz = exp_q.size();
    if (chk) check_outputs();
    push  = reset && if_valid && (sz < DEPTH) && !flush;
    pop   = reset && (sz > 0) && id_ready && !flush;
    stall = reset && (sz > 0) && !id_ready && !flush;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      m_stall = 16'd0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({if_pc, if_instr});
    end
    if (reset && stall && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
    last_acc = push;
    #1;
  endtask

  // Fetch-side driver: hold the word until the queue accepts it (bounded).
  task automatic push_word(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    last_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (last_acc) break;
    end
    check("push_accepted", 32'(last_acc), 32'd1);
    if_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'h0;
    if_instr = 32'h0;
    flush    = 1'b0;
    id_ready = 1'b0;
    m_stall  = 16'd0;
    last_acc = 1'b0;

    // Reset values, held without any clock edge having occurred.
    #2;
    check("rst_count",    32'(count),     32'd0);
    check("rst_if_ready", 32'(if_ready),  32'd1);
    check("rst_id_valid", 32'(id_valid),  32'd0);
    check("rst_id_pc",    id_pc,          32'h0);
    check("rst_id_instr", id_instr,       32'h0);
    check("rst_stall",    32'(stall_cnt), 32'd0);

    // Release mid-cycle; the first edge afterwards takes the first push.
    #20;
    reset = 1'b1;

    // Three words with decode stalled.
    push_word(32'h0000_0000, 32'h2001_0005);
    check("first_push_count", 32'(count), 32'd1);
    push_word(32'h0000_0004, 32'h2002_0003);
    push_word(32'h0000_0008, 32'h0022_1820);
    check("r3_count",    32'(count),     32'd3);
    check("r3_id_pc",    id_pc,          32'h0000_0000);
    check("r3_id_instr", id_instr,       32'h2001_0005);
    check("r3_stall",    32'(stall_cnt), 32'd2);

    // Fill to DEPTH, then a held fifth word is refused, even alongside a pop.
    push_word(32'h0000_000C, 32'h0000_0013);
    check("full_if_ready", 32'(if_ready), 32'd0);
    check("full_count",    32'(count),    32'd4);
    if_valid = 1'b1;
    if_pc    = 32'h0000_0010;
    if_instr = 32'h0000_0033;
    step(1'b1);
    check("full_hold_count", 32'(count), 32'd4);
    id_ready = 1'b1;
    step(1'b1);
    check("pop_full_count",    32'(count),    32'd3);
    check("pop_full_if_ready", 32'(if_ready), 32'd1);
    id_ready = 1'b0;
    push_word(32'h0000_0010, 32'h0000_0033);
    check("refill_count", 32'(count), 32'd4);

    // Drain, then stream with decode always ready: steady count of one.
    id_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b1);
    check("drained_count", 32'(count), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if_valid = 1'b1;
      if_pc    = 32'h0000_0100 + 32'(i * 4);
      if_instr = $urandom;
      step(1'b1);
    end
    check("stream_count", 32'(count), 32'd1);
    check("stream_id_pc", id_pc,      32'h0000_012C);
    if_valid = 1'b0;
    step(1'b1);

    // Flush with three entries and a push in the flush cycle.
    id_ready = 1'b0;
    push_word(32'h0000_0200, 32'h1111_0001);
    push_word(32'h0000_0204, 32'h1111_0002);
    push_word(32'h0000_0208, 32'h1111_0003);
    check("preflush_count", 32'(count), 32'd3);
    flush    = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'h0000_02F0;
    if_instr = 32'h2222_0000;
    step(1'b1);
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_count",    32'(count),    32'd0);
    check("flush_id_valid", 32'(id_valid), 32'd0);
    check("flush_id_instr", id_instr,      32'h0);
    push_word(32'h0000_0300, 32'h3333_0000);
    check("postflush_id_pc", id_pc, 32'h0000_0300);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      if_valid = 1'($urandom_range(0, 1));
      id_ready = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 15) == 0);
      if_pc    = 32'h0000_1000 + 32'(i * 4);
      if_instr = $urandom;
      step(1'b1);
    end
    flush    = 1'b0;
    if_valid = 1'b0;

    // Asynchronous reset mid-cycle with two entries queued.
    id_ready = 1'b0;
    flush    = 1'b1;
    step(1'b1);
    flush = 1'b0;
    push_word(32'h0000_0400, 32'h4444_0001);
    push_word(32'h0000_0404, 32'h4444_0002);
    check("prerst_count", 32'(count), 32'd2);
    if_valid = 1'b1;
    if_pc    = 32'h0000_0500;
    if_instr = 32'h5555_0000;
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_stall = 16'd0;
    check("arst_count",    32'(count),     32'd0);
    check("arst_id_valid", 32'(id_valid),  32'd0);
    check("arst_id_pc",    id_pc,          32'h0);
    check("arst_id_instr", id_instr,       32'h0);
    check("arst_stall",    32'(stall_cnt), 32'd0);
    check("arst_if_ready", 32'(if_ready),  32'd1);
    step(1'b1);
    check("rst_push_lost", 32'(count), 32'd0);
    #3;
    reset = 1'b1;
    step(1'b1);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_id_pc", id_pc,      32'h0000_0500);
    if_valid = 1'b0;

    // Long stall: counter saturates and survives a flush.
    id_ready = 1'b0;
    for (int i = 0; i < 70000; i++) step(1'b0);
    check("sat_stall", 32'(stall_cnt), 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    flush = 1'b1;
    step(1'b1);
    flush = 1'b0;
    check("sat_after_flush", 32'(stall_cnt), 32'h0000_FFFF);
    check("flush_empty",     32'(count),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-004 The block SHALL have port if_valid  input  1  the fetch stage presents a fetched instruction.
REQ-005 The block SHALL have port if_pc  input  32  the PC of the presented instruction.
REQ-006 The block SHALL have port if_instr  input  32  the presented instruction word.
REQ-007 The block SHALL have port if_ready  output  1  the queue can accept a push this cycle.
REQ-008 The block SHALL have port flush  input  1  discard all queued instructions (taken branch or jump resolved downstream).
REQ-009 The block SHALL have port id_ready  input  1  the decode stage accepts the head entry this cycle.
REQ-010 The block SHALL have port id_valid  output  1  the head entry is valid.
REQ-011 The block SHALL have port id_pc  output  32  the PC of the head entry.
REQ-012 The block SHALL have port id_instr  output  32  the instruction of the head entry.
REQ-013 The block SHALL have port count  output  5  the number of occupied entries, 0..DEPTH.
REQ-014 The block SHALL have port stall_cnt  output  16  the number of cycles with id_valid=1 and id_ready=0, saturating.

Function
REQ-015 The block SHALL push when if_valid=1 and if_ready=1 and flush=0, writing {if_pc, if_instr} at the tail.
REQ-016 The block SHALL pop when id_valid=1 and id_ready=1 and flush=0, advancing the head.
REQ-017 The block SHALL drive if_ready=1 exactly when count<DEPTH; a push into a full queue is refused even when a pop occurs in the same cycle.
REQ-018 The block SHALL drive id_valid=1 exactly when count>0; there is no bypass, so an instruction pushed in cycle N is visible at id_* in cycle N+1 at the earliest.
REQ-019 The block SHALL drive id_pc and id_instr from the registered head entry; when count=0 it SHALL drive id_instr=32'h00000000 (NOP) and id_pc=32'h00000000.
REQ-020 The block SHALL handle a simultaneous push and pop with 0<count<DEPTH by leaving count unchanged and keeping FIFO order.
REQ-021 The block SHALL wrap the read and write pointers modulo DEPTH and distinguish full from empty using count.
REQ-022 The block SHALL give flush priority: in a flush cycle it sets count=0 and head=tail, and ignores any push or pop in that cycle.
REQ-023 The block SHALL keep id_valid=0 in the cycle after a flush unless a push occurs in that cycle; the following instruction then appears one cycle later.
REQ-024 The block SHALL increment stall_cnt by 1 in each cycle where id_valid=1, id_ready=0 and flush=0, and SHALL hold it at 16'hFFFF once saturated; flush does not clear it.
REQ-025 The block SHALL keep entry storage contents out of any observable output except through the head entry.

Reset
REQ-026 While reset=0, the block SHALL hold count=0, both pointers=0, id_valid=0, id_pc=0, id_instr=0, stall_cnt=0 and if_ready=1, all asynchronously.
REQ-027 A reset asserted mid-operation SHALL discard all entries within the same cycle; a push presented in that cycle SHALL be lost.
REQ-028 The block SHALL accept its first push on the first rising clk edge after reset returns to 1.

Verification
REQ-029 Reset then push three words with id_ready=0 (PC 0x0/0x4/0x8, instr 0x20010005/0x20020003/0x00221820) -> count=3; id_pc=0x0; id_instr=0x20010005; stall_cnt increments from the cycle after the first push.
REQ-030 Push five words with DEPTH=4 and id_ready=0 -> if_ready=0 after the fourth push; the fifth word is held by fetch; count=4; after one pop, if_ready=1.
REQ-031 Push continuously while id_ready=1 -> steady state count=1; id_pc sequence 0x0, 0x4, 0x8 ... with no gaps and no duplicates; pointers wrap correctly past DEPTH.
REQ-032 Assert flush with count=3 while if_valid=1 -> next cycle count=0, id_valid=0, id_instr=0x00000000; the flush-cycle push is dropped; the next push appears 1 cycle after its acceptance.
REQ-033 Drop reset to 0 asynchronously mid-cycle with count=2 -> outputs reach their reset values before the next clk edge; stall_cnt=0.
REQ-034 Hold id_valid=1 and id_ready=0 for 70000 cycles -> stall_cnt=0xFFFF and stays at 0xFFFF.
